// File: rtl/q2_pkg.sv
// -----------------------------------------------------------------------------
// q2_pkg
// Shared definitions for the Q2 processor sequencer.
//   state_t  : 4-bit state code {s3,s2,s1,s0}
//   phase_e  : 3-clock phase within a state (settle / strobe / decide)
//   next_state() : successor of a state, evaluated in the decide phase
// -----------------------------------------------------------------------------
package q2_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_FETCH = 4'b0000;
   localparam state_t ST_DEREF = 4'b0001;
   localparam state_t ST_LOAD  = 4'b0010;
   localparam state_t ST_EXEC  = 4'b0011;
   localparam state_t ST_ALU0  = 4'b1000;  // ALU states are 1bbb, bbb = bit index
   localparam state_t ST_ALU7  = 4'b1111;

   typedef enum logic [1:0] {
      PH_SETTLE = 2'd0,
      PH_STROBE = 2'd1,
      PH_DECIDE = 2'd2
   } phase_e;

   // Successor state. Anything not listed (EXEC, ALU bit 7, the unreachable
   // 01xx codes) returns to FETCH.
   function automatic state_t next_state(input state_t cur,
                                         input logic   deref,
                                         input logic   o2);
      state_t nxt;
      nxt = ST_FETCH;
      if (cur[3]) begin
         nxt = (cur == ST_ALU7) ? ST_FETCH : state_t'(cur + 4'd1);
      end else begin
         case (cur)
            ST_FETCH: nxt = deref ? ST_DEREF : (o2 ? ST_EXEC : ST_LOAD);
            ST_DEREF: nxt = o2 ? ST_EXEC : ST_LOAD;
            ST_LOAD:  nxt = ST_ALU0;
            default:  nxt = ST_FETCH;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/q2_sw_sync.sv
// -----------------------------------------------------------------------------
// q2_sw_sync
// Front-panel switch conditioner: SYNC_STAGES-deep synchroniser followed by a
// debouncer that accepts a new level only after it has held for DEBOUNCE_CNT
// consecutive clocks.
//   clk, rst_n : system clock, asynchronous active-low reset
//   sw_i       : raw asynchronous switch input
//   level_o    : registered, debounced switch level
//   rise_o     : one-clock pulse, coincident with level_o going 0 -> 1
// -----------------------------------------------------------------------------
module q2_sw_sync #(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CNT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_i,
   output logic level_o,
   output logic rise_o
);

   localparam int CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   level_q;
   logic                   rise_q;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
   // pre-edge value of its neighbours; blocking here would collapse the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
         rise_q <= 1'b0;
         // The counter runs only while the synchronised input disagrees with
         // the accepted level; any agreement restarts the hold window.
         if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
               level_q <= synced;
               rise_q  <= synced;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;

endmodule

// File: rtl/q2_sequencer.sv
// -----------------------------------------------------------------------------
// q2_sequencer
// Q2 processor state sequencer. Steps each instruction through FETCH,
// optional DEREF, LOAD + 8 bit-serial ALU states or EXEC; every state lasts
// three clocks (settle, strobe, decide). Owns the run/step front panel and
// only ever parks in FETCH phase 0.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   run_sw         : run switch (async level)
//   step_sw        : single-step switch (async pulse)
//   deref, o2      : indirect bit and opcode bit 2 of the opcode register
//   s0..s3         : state code {s3,s2,s1,s0}
//   ws             : write strobe, high in phase 1 of every state
//   halted         : high while parked in FETCH phase 0
//   instr_done     : one-clock pulse on re-entering FETCH after ALU bit 7/EXEC
// -----------------------------------------------------------------------------
module q2_sequencer
   import q2_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CNT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_sw,
   input  logic step_sw,
   input  logic deref,
   input  logic o2,
   output logic s0,
   output logic s1,
   output logic s2,
   output logic s3,
   output logic ws,
   output logic halted,
   output logic instr_done
);

   logic   run_q;
   logic   step_rise;
   logic   run_rise_unused;    // run acts on its level only
   logic   step_level_unused;  // step acts on its rising edge only

   state_t state_q;
   phase_e phase_q;
   logic   ws_q;
   logic   halted_q;
   logic   done_q;
   logic   token_q;

   logic   go;
   logic   illegal;

   q2_sw_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) u_run_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_i   (run_sw),
      .level_o(run_q),
      .rise_o (run_rise_unused)
   );

   q2_sw_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
   ) u_step_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sw_i   (step_sw),
      .level_o(step_level_unused),
      .rise_o (step_rise)
   );

   // Run wins over a pending step; either one lets FETCH phase 0 advance.
   assign go      = run_q | token_q;
   assign illegal = (state_q[3:2] == 2'b01);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FETCH;
         phase_q  <= PH_SETTLE;
         ws_q     <= 1'b0;
         halted_q <= 1'b1;
         done_q   <= 1'b0;
         token_q  <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low each clock; the branches below
         // raise them for exactly one cycle.
         ws_q     <= 1'b0;
         halted_q <= 1'b0;
         done_q   <= 1'b0;

         if (illegal) begin
            state_q <= ST_FETCH;
            phase_q <= PH_SETTLE;
         end else begin
            case (phase_q)
               PH_SETTLE: begin
                  if (state_q != ST_FETCH) begin
                     phase_q <= PH_STROBE;
                     ws_q    <= 1'b1;
                  end else if (go) begin
                     // Leaving FETCH consumes (or discards) any step token.
                     phase_q <= PH_STROBE;
                     ws_q    <= 1'b1;
                     token_q <= 1'b0;
                  end else begin
                     // Parked: this is the only place a step edge is accepted,
                     // so edges arriving mid-instruction are simply dropped.
                     halted_q <= 1'b1;
                     if (step_rise) begin
                        token_q <= 1'b1;
                     end
                  end
               end
               PH_STROBE: begin
                  phase_q <= PH_DECIDE;
               end
               PH_DECIDE: begin
                  phase_q <= PH_SETTLE;
                  state_q <= next_state(state_q, deref, o2);
                  done_q  <= (state_q == ST_EXEC) || (state_q == ST_ALU7);
               end
               default: begin
                  phase_q <= PH_SETTLE;
                  state_q <= ST_FETCH;
               end
            endcase
         end
      end
   end

   assign {s3, s2, s1, s0} = state_q;
   assign ws               = ws_q;
   assign halted           = halted_q;
   assign instr_done       = done_q;

endmodule

// File: tb/tb_q2_sequencer.sv
// -----------------------------------------------------------------------------
// tb_q2_sequencer
// Self-checking bench for q2_sequencer. A behavioural model expands every
// started instruction into its clock-by-clock plan of expected outputs and
// models the switch conditioning as "raw level held for DEBOUNCE_CNT samples,
// seen SYNC_STAGES clocks late". Directed scenarios add literal expectations,
// followed by a randomized run/step/opcode phase.
// -----------------------------------------------------------------------------
module tb_q2_sequencer;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int HW   = SYNC + DEB;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic run_sw = 1'b0;
   logic step_sw = 1'b0;
   logic deref = 1'b0;
   logic o2 = 1'b0;
   logic s0, s1, s2, s3, ws, halted, instr_done;

   always #5 clk = ~clk;

   q2_sequencer #(
      .SYNC_STAGES (SYNC),
      .DEBOUNCE_CNT(DEB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_sw    (run_sw),
      .step_sw   (step_sw),
      .deref     (deref),
      .o2        (o2),
      .s0        (s0),
      .s1        (s1),
      .s2        (s2),
      .s3        (s3),
      .ws        (ws),
      .halted    (halted),
      .instr_done(instr_done)
   );

   // ---------------------------------------------------------------- checking
   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // ------------------------------------------------------------------- model
   typedef struct packed {
      logic [3:0] st;
      logic       ws;
      logic       halted;
      logic       done;
   } exp_t;

   exp_t          plan[$];
   exp_t          m_exp;
   logic [HW-1:0] m_run_hist, m_step_hist;
   logic          m_run_lvl, m_step_lvl, m_step_rise, m_token, m_new;

   function automatic exp_t mk(input logic [3:0] st, input logic w, input logic h, input logic d);
      exp_t e;
      e.st = st; e.ws = w; e.halted = h; e.done = d;
      return e;
   endfunction

   // Debounced level: the last DEB synchronised samples (raw delayed by SYNC)
   // must all agree before the level changes.
   function automatic logic deb_level(input logic [HW-1:0] h, input logic lvl);
      logic [DEB-1:0] win;
      win = h[HW-1:SYNC];
      if (&win)  return 1'b1;
      if (~|win) return 1'b0;
      return lvl;
   endfunction

   task automatic push3(input logic [3:0] st);
      plan.push_back(mk(st, 1'b0, 1'b0, 1'b0));
      plan.push_back(mk(st, 1'b1, 1'b0, 1'b0));
      plan.push_back(mk(st, 1'b0, 1'b0, 1'b0));
   endtask

   // Whole instruction from the clock after FETCH phase 0 up to and including
   // the FETCH phase 0 clock that carries instr_done.
   task automatic build_plan(input logic d, input logic op);
      plan.push_back(mk(4'b0000, 1'b1, 1'b0, 1'b0));
      plan.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0));
      if (d) push3(4'b0001);
      if (op) begin
         push3(4'b0011);
      end else begin
         push3(4'b0010);
         for (int b = 0; b < 8; b++) push3(4'b1000 | 4'(b));
      end
      plan.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b1));
   endtask

   task automatic model_reset();
      plan.delete();
      m_exp       = mk(4'b0000, 1'b0, 1'b1, 1'b0);
      m_run_hist  = '0;
      m_step_hist = '0;
      m_run_lvl   = 1'b0;
      m_step_lvl  = 1'b0;
      m_step_rise = 1'b0;
      m_token     = 1'b0;
   endtask

   task automatic model_step();
      if (plan.size() != 0) begin
         m_exp = plan.pop_front();
      end else if (m_run_lvl || m_token) begin
         m_token = 1'b0;
         build_plan(deref, o2);
         m_exp = plan.pop_front();
      end else begin
         if (m_step_rise) m_token = 1'b1;
         m_exp = mk(4'b0000, 1'b0, 1'b1, 1'b0);
      end
      m_run_hist  = {m_run_hist[HW-2:0], run_sw};
      m_step_hist = {m_step_hist[HW-2:0], step_sw};
      m_run_lvl   = deb_level(m_run_hist, m_run_lvl);
      m_new       = deb_level(m_step_hist, m_step_lvl);
      m_step_rise = m_new & ~m_step_lvl;
      m_step_lvl  = m_new;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Per-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      check("state", {s3, s2, s1, s0}, m_exp.st);
      check("ws", ws, m_exp.ws);
      check("halted", halted, m_exp.halted);
      check("instr_done", instr_done, m_exp.done);
   end

   // Observation log for the directed literal checks.
   int         done_cyc[$];
   int         strobe_cyc[$];
   logic [3:0] strobe_st[$];

   initial forever begin
      @(negedge clk);
      if (instr_done) done_cyc.push_back(cyc);
      if (ws) begin
         strobe_cyc.push_back(cyc);
         strobe_st.push_back({s3, s2, s1, s0});
      end
   end

   task automatic clear_log();
      done_cyc.delete();
      strobe_cyc.delete();
      strobe_st.delete();
   endtask

   task automatic wait_dones(input int n, input int budget, input string nm);
      int k = 0;
      while (done_cyc.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(nm, done_cyc.size() >= n, 1);
   endtask

   task automatic wait_halted(input int budget, input string nm);
      bit hit = 1'b0;
      for (int k = 0; k < budget && !hit; k++) begin
         @(negedge clk);
         if (halted) hit = 1'b1;
      end
      check(nm, hit, 1);
   endtask

   task automatic wait_state(input logic [3:0] st, input logic need_ws, input int budget,
                             input string nm);
      bit hit = 1'b0;
      for (int k = 0; k < budget && !hit; k++) begin
         @(negedge clk);
         if ({s3, s2, s1, s0} == st && (!need_ws || ws)) hit = 1'b1;
      end
      check(nm, hit, 1);
   endtask

   // Period and strobe sequence between the 2nd and 3rd instr_done.
   task automatic check_period(input int period, input logic [3:0] seq[], input string nm);
      int d1, d2, n;
      d1 = done_cyc[1];
      d2 = done_cyc[2];
      check({nm, " period"}, d2 - d1, period);
      n = 0;
      for (int i = 0; i < strobe_cyc.size(); i++) begin
         if (strobe_cyc[i] > d1 && strobe_cyc[i] < d2) begin
            if (n < seq.size()) check({nm, " strobe state"}, strobe_st[i], seq[n]);
            n++;
         end
      end
      check({nm, " strobe count"}, n, seq.size());
   endtask

   // -------------------------------------------------------------- stimulus
   logic [3:0] alu_seq[]  = '{4'h0, 4'h2, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
   logic [3:0] exec_seq[] = '{4'h0, 4'h1, 4'h3};

   initial begin
      int hold;

      // Reset, then idle with run off: parked in FETCH phase 0.
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      repeat (40) @(negedge clk);
      check("idle state", {s3, s2, s1, s0}, 0);
      check("idle halted", halted, 1);
      check("idle ws", ws, 0);
      check("idle no done", done_cyc.size(), 0);

      // ALU instruction, no deref: 30 clocks, 10 strobes.
      deref = 1'b0; o2 = 1'b0;
      run_sw = 1'b1;
      clear_log();
      wait_dones(3, 200, "wait alu dones");
      if (done_cyc.size() >= 3) check_period(30, alu_seq, "alu");
      run_sw = 1'b0;
      wait_halted(100, "wait halt after alu");

      // EXEC with deref: 9 clocks, 3 strobes.
      deref = 1'b1; o2 = 1'b1;
      run_sw = 1'b1;
      clear_log();
      wait_dones(3, 100, "wait exec dones");
      if (done_cyc.size() >= 3) check_period(9, exec_seq, "exec deref");
      run_sw = 1'b0;
      wait_halted(100, "wait halt after exec");

      // Single step: short glitches ignored, one press = one instruction,
      // a second press mid-instruction is dropped.
      deref = 1'b0; o2 = 1'b0;
      clear_log();
      repeat (2) begin
         step_sw = 1'b1;
         repeat (DEB - 1) @(negedge clk);
         step_sw = 1'b0;
         repeat (8) @(negedge clk);
      end
      check("glitch no done", done_cyc.size(), 0);
      check("glitch halted", halted, 1);
      step_sw = 1'b1;
      repeat (HW) @(negedge clk);
      step_sw = 1'b0;
      repeat (8) @(negedge clk);
      check("step in flight", halted, 0);
      step_sw = 1'b1;
      repeat (HW) @(negedge clk);
      step_sw = 1'b0;
      repeat (60) @(negedge clk);
      check("step one instr", done_cyc.size(), 1);
      check("step halted", halted, 1);
      check("step state", {s3, s2, s1, s0}, 0);

      // Run dropped during ALU bit 3: instruction completes, then halts.
      run_sw = 1'b1;
      wait_state(4'b1011, 1'b0, 200, "wait alu bit3");
      run_sw = 1'b0;
      clear_log();
      wait_halted(100, "wait halt after drop");
      check("drop one done", done_cyc.size(), 1);
      if (strobe_st.size() > 0) check("drop last strobe", strobe_st[strobe_st.size()-1], 4'hF);
      check("drop state", {s3, s2, s1, s0}, 0);

      // Asynchronous reset during ALU 1101 phase 1.
      run_sw = 1'b1;
      wait_state(4'b1101, 1'b1, 200, "wait alu 1101 strobe");
      #2 rst_n = 1'b0;
      #1;
      check("async rst state", {s3, s2, s1, s0}, 0);
      check("async rst ws", ws, 0);
      check("async rst halted", halted, 1);
      check("async rst done", instr_done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < HW; i++) begin
         @(negedge clk);
         check("halted after reset", halted, 1);
      end
      begin
         bit left = 1'b0;
         for (int k = 0; k < 10 && !left; k++) begin
            @(negedge clk);
            if (!halted) left = 1'b1;
         end
         check("leaves after debounce", left, 1);
      end

      // Randomized run/step/opcode traffic; opcode bits only change while
      // the model says the machine sits in FETCH phase 0.
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (hold == 0) begin
            run_sw  = ($urandom_range(0, 2) == 0);
            step_sw = ($urandom_range(0, 3) == 0);
            hold    = $urandom_range(1, 40);
         end else begin
            hold--;
         end
         if (plan.size() == 0) begin
            deref = 1'($urandom_range(0, 1));
            o2    = 1'($urandom_range(0, 1));
         end
      end

      run_sw  = 1'b0;
      step_sw = 1'b0;
      wait_halted(200, "final halt");
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/q2_sequencer.md
Name: q2_sequencer

Overview:
- Generates the Q2 processor state bits s0..s3 and the write strobe ws that the control decoder consumes. Together they sequence every instruction through FETCH, optional DEREF, LOAD/EXEC and an 8-step bit-serial ALU phase.
- Also owns the front-panel run/step interface: it synchronises and debounces the switches and halts cleanly on instruction boundaries.
- Sits between the front-panel switches and the control decoder.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each switch synchroniser (minimum 2).
- DEBOUNCE_CNT, 16, consecutive clocks a synchronised switch level must hold before it is accepted (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run_sw  in  1  front-panel run switch, asynchronous, level.
- step_sw  in  1  front-panel single-step switch, asynchronous, pulse.
- deref  in  1  indirect-addressing bit of the current opcode register.
- o2  in  1  opcode bit 2; 0 selects an ALU-class op, 1 selects an EXEC-class op.
- s0, s1, s2, s3  out  1 each  state code {s3,s2,s1,s0}.
- ws  out  1  write strobe.
- halted  out  1  high while parked in FETCH phase 0.
- instr_done  out  1  one-clock pulse when an instruction retires.

Behaviour:
- State encodings {s3,s2,s1,s0}:
  - FETCH = 0000
  - DEREF = 0001
  - LOAD = 0010
  - EXEC = 0011
  - ALU = 1bbb, where bbb is the bit index 0..7 (1000..1111).
- Each state lasts exactly 3 clocks, using a 2-bit phase counter:
  - P0: settle, ws=0.
  - P1: strobe, ws=1.
  - P2: decide, ws=0; registers written in P1 are now visible.
- ws is registered and high only in P1.
- Transitions are evaluated in P2 and take effect on the next clock, landing in P0:
  - FETCH: deref=1 -> DEREF; else o2=0 -> LOAD; else EXEC.
  - DEREF: o2=0 -> LOAD; else EXEC.
  - LOAD -> ALU 1000.
  - ALU 1bbb, bbb<7 -> ALU 1(bbb+1); ALU 1111 -> FETCH (bit index wraps, no further state).
  - EXEC -> FETCH.
- Instruction cycle counts:
  - ALU instruction without deref: 3+3+24 = 30 clocks.
  - ALU instruction with deref: 33 clocks.
  - EXEC instruction: 6 clocks; 9 with deref.
- instr_done pulses high on the clock that enters FETCH P0 from ALU 1111 or EXEC.
- Running and halting:
  - run_q and step_q are the synchronised, debounced versions of run_sw and step_sw.
  - The machine advances out of FETCH P0 only if run_q=1 or a step token is pending. Otherwise it stays in FETCH P0 with halted=1 and ws=0.
  - A step token is set on a debounced rising edge of step_q, consumed when FETCH P0 is left, and holds at most one pending step. Further edges while a token is pending or an instruction is in flight are dropped.
  - run_q falling mid-instruction completes the current instruction, then halts at FETCH P0. The machine never stops in any other state or phase.
  - run_q and a step edge together: run wins; the token is discarded when leaving FETCH.
- halted is registered: 1 in FETCH P0 when not advancing, 0 otherwise.
- Reset (asynchronous, any time, including mid-ALU):
  - State returns to FETCH, phase to P0.
  - Outputs: ws=0, halted=1, instr_done=0, s0..s3=0.
  - Synchronisers, debounce counters and the step token are cleared.
  - After reset release the machine advances only once a debounced run or step is seen, i.e. at least SYNC_STAGES+DEBOUNCE_CNT clocks later.
- Illegal state codes 0100..0111 are unreachable. If one is ever entered, the next clock forces FETCH P0.

Decomposition:
- Shared package q2_pkg holds:
  - State code constants ST_FETCH, ST_DEREF, ST_LOAD, ST_EXEC, ST_ALU0.
  - Phase constants PH_SETTLE, PH_STROBE, PH_DECIDE.
- One sub-module, q2_sw_sync, instanced twice:
  - SYNC_STAGES flop chain, DEBOUNCE_CNT counter, registered level output and rising-edge pulse.
  - Same clk/rst_n as the sequencer.

Test Plan:
- Reset held low, then released with run_sw=0 -> s=0000, ws=0, halted=1 indefinitely; no instr_done.
- run_sw=1, deref=0, o2=0 -> after debounce: state sequence 0000, 0010, 1000..1111; ws high once per state (10 strobes); instr_done pulses 30 clocks after leaving FETCH.
- run_sw=1, deref=1, o2=1 -> sequence 0000, 0001, 0011, back to 0000; instr_done after 9 clocks; 3 ws pulses.
- run_sw=0, single step_sw pulse with 3-clock glitches beforehand -> glitches ignored; exactly one instruction executes, then halted=1; a second step_sw pulse mid-instruction causes no extra instruction.
- run_sw dropped during ALU bit 3 -> instruction completes through 1111; halt in FETCH P0 with halted=1.
- rst_n asserted during ALU 1101 P1 -> s=0000, ws=0 immediately (asynchronous); after release the machine stays halted until run is debounced.
